// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: instruction opcodes, ALU opcode map, FSM state encoding and field widths
// shared by the accumulator-machine sequencer and its decoder.
package alu_ctrl_pkg;

  localparam int OP_W     = 4;
  localparam int ALU_OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_STO = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_AND = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NEG = 4'h7;
  localparam logic [OP_W-1:0] OP_SCL = 4'h8;
  localparam logic [OP_W-1:0] OP_SEL = 4'h9;
  localparam logic [OP_W-1:0] OP_JMP = 4'hA;
  localparam logic [OP_W-1:0] OP_SKZ = 4'hB;
  localparam logic [OP_W-1:0] OP_HLT = 4'hC;

  localparam logic [ALU_OP_W-1:0] ALU_NOP = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_NEG = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SCL = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SEL = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPER   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational instruction-op decoder. Illegal-op trapping (ops D..F)
// is reported only when ALU_CTRL_TRAP_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                is_alu,
  output logic                is_mem_rd,
  output logic                is_illegal
);

  always_comb begin
    alu_opcode = ALU_NOP;
    is_alu     = 1'b0;
    // ALU ops 3..9 map contiguously onto ALU opcodes 1..7
    if (op >= OP_ADD && op <= OP_SEL) begin
      alu_opcode = ALU_OP_W'(op - 4'd2);
      is_alu     = 1'b1;
    end
    is_mem_rd = is_alu || (op == OP_LDA);
`ifdef ALU_CTRL_TRAP_EN
    is_illegal = (op > OP_HLT);
`else
    is_illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: fetch/decode/execute sequencer owning pc, ir and the accumulator for an external
// registered 8-bit ALU. Optional build macro: ALU_CTRL_TRAP_EN (halt with illegal=1 on ops D..F).
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rom_rd,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [OP_W+ADDR_W-1:0] rom_data,
  output logic                   ram_rd,
  output logic                   ram_wr,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic [ALU_OP_W-1:0]    alu_opcode,
  output logic [DATA_W-1:0]      alu_accum,
  output logic [DATA_W-1:0]      alu_data,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   zero,
  output logic                   halted,
  output logic                   illegal
);

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        pc;
  logic [OP_W+ADDR_W-1:0]   ir;
  logic [DATA_W-1:0]        acc;
  logic                     illegal_q;
  logic                     fetch_c;

  logic [OP_W-1:0]          op;
  logic [ADDR_W-1:0]        addr;
  logic [ALU_OP_W-1:0]      dec_alu_opcode;
  logic                     dec_is_alu;
  logic                     dec_is_mem_rd;
  logic                     dec_is_illegal;

  assign op   = ir[ADDR_W +: OP_W];
  assign addr = ir[ADDR_W-1:0];

  alu_ctrl_decode u_decode (
    .op         (op),
    .alu_opcode (dec_alu_opcode),
    .is_alu     (dec_is_alu),
    .is_mem_rd  (dec_is_mem_rd),
    .is_illegal (dec_is_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_DECODE: begin
          ir <= rom_data;
          pc <= pc + ADDR_W'(1);
        end
        ST_OPER: begin
          if (dec_is_illegal)
            illegal_q <= 1'b1;
          else if (op == OP_JMP)
            pc <= addr;
          else if (op == OP_SKZ && zero)
            pc <= pc + ADDR_W'(1);
        end
        ST_EXEC: if (op == OP_LDA) acc <= ram_rdata;
        ST_WB:   acc <= alu_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    fetch_c    = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    alu_opcode = ALU_NOP;
    alu_data   = '0;
    case (state)
      ST_FETCH: begin
        fetch_c   = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_OPER;
      ST_OPER: begin
        if (dec_is_illegal || op == OP_HLT) begin
          state_nxt = ST_HALT;
        end else if (dec_is_mem_rd) begin
          ram_rd    = 1'b1;
          state_nxt = ST_EXEC;
        end else begin
          ram_wr    = (op == OP_STO);
          state_nxt = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (dec_is_alu) begin
          alu_opcode = dec_alu_opcode;
          alu_data   = ram_rdata;
          state_nxt  = ST_WB;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // reset parks the FSM in FETCH; keep the ROM strobe quiet until reset is released
  assign rom_rd    = fetch_c & reset;
  assign rom_addr  = pc;
  assign ram_addr  = addr;
  assign ram_wdata = acc;
  assign alu_accum = acc;
  assign halted    = (state == ST_HALT);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench with behavioural ROM, RAM and registered ALU models around alu_ctrl.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rom_rd, ram_rd, ram_wr, zero, halted, illegal;
  logic [11:0] rom_addr, ram_addr;
  logic [15:0] rom_data = '0;
  logic [7:0]  ram_wdata, ram_rdata = '0, alu_accum, alu_data, alu_out = '0;
  logic [2:0]  alu_opcode;

  logic [15:0] rom [4096];
  logic [7:0]  ram [4096];
  int          wr_count;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .alu_opcode(alu_opcode), .alu_accum(alu_accum), .alu_data(alu_data),
    .alu_out(alu_out), .zero(zero), .halted(halted), .illegal(illegal)
  );

  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom[rom_addr];
    if (ram_rd) ram_rdata <= ram[ram_addr];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= 0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (ram_wr) begin
      wr_count <= wr_count + 1;
      wr_addr  <= ram_addr;
      wr_data  <= ram_wdata;
    end
  end

  // ALU model; SCL here scales as acc*5+2
  always @(posedge clk) begin
    case (alu_opcode)
      3'b001: alu_out <= alu_accum + alu_data;
      3'b010: alu_out <= alu_accum - alu_data;
      3'b011: alu_out <= alu_accum & alu_data;
      3'b100: alu_out <= alu_accum ^ alu_data;
      3'b101: alu_out <= 8'(8'd0 - alu_accum);
      3'b110: alu_out <= 8'((alu_accum << 2) + alu_accum + 8'd2);
      3'b111: alu_out <= alu_data;
      default: ;
    endcase
  end
  assign zero = (alu_accum == 8'd0);

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 8'h00;
    end
  endtask

  // ends on the negedge of cycle 0 (first FETCH)
  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_fetch(input logic [11:0] a, input string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rom_rd && rom_addr == a) ok = 1;
      else step(1);
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int strobes;
    bit done;

    #1 reset = 1'b0;
    #2;
    check("reset_outputs",
          {rom_rd, ram_rd, ram_wr, halted, illegal, alu_opcode, rom_addr, ram_addr, alu_accum, alu_data, ram_wdata},
          '0);

    vecs[0] = '{4'h3, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{4'h3, 8'hFF, 8'h02, 8'h01};
    vecs[2] = '{4'h4, 8'h03, 8'h05, 8'hFE};
    vecs[3] = '{4'h5, 8'hF0, 8'h3C, 8'h30};
    vecs[4] = '{4'h6, 8'hFF, 8'h0F, 8'hF0};
    vecs[5] = '{4'h7, 8'h01, 8'h55, 8'hFF};
    vecs[6] = '{4'h8, 8'h10, 8'hAA, 8'h52};
    vecs[7] = '{4'h9, 8'h20, 8'h3C, 8'h3C};
    vecs[8] = '{4'h0, 8'h77, 8'h11, 8'h77};
    vecs[9] = '{4'h1, 8'h77, 8'h9A, 8'h9A};

    // LDA 0x100; <op> 0x101; STO 0x102; HLT
    for (int v = 0; v < 10; v++) begin
      reset = 1'b0;
      clear_mem();
      ram[12'h100] = vecs[v].a;
      ram[12'h101] = vecs[v].d;
      rom[0] = 16'h1100;
      rom[1] = {vecs[v].op, 12'h101};
      rom[2] = 16'h2102;
      rom[3] = 16'hC000;
      release_reset();
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
        if (halted) done = 1;
        else step(1);
      end
      check($sformatf("vec%0d_halted", v), {31'd0, done}, 32'd1);
      check($sformatf("vec%0d_store", v), {wr_count[7:0], wr_addr, wr_data}, {8'd1, 12'h102, vecs[v].exp});
    end

    // reset asserted during EXEC of ADD
    reset = 1'b0;
    clear_mem();
    ram[12'h010] = 8'h05;
    ram[12'h011] = 8'h03;
    rom[0] = 16'h1010;
    rom[1] = 16'h3011;
    rom[2] = 16'h2020;
    rom[3] = 16'hC000;
    release_reset();
    step(7);
    check("exec_add_drive", {alu_opcode, alu_data, alu_accum}, {3'b001, 8'h03, 8'h05});
    #1 reset = 1'b0;
    #1;
    check("async_reset_outputs",
          {rom_rd, ram_rd, ram_wr, halted, alu_opcode, rom_addr, alu_accum, alu_data}, '0);
    release_reset();
    check("after_reset_fetch", {rom_rd, rom_addr, alu_accum}, {1'b1, 12'h000, 8'h00});

    // same program runs to completion: store lands in cycle 11
    reset = 1'b0;
    release_reset();
    cyc = 0;
    while (!ram_wr && cyc < 60) begin
      step(1);
      cyc++;
    end
    check("prog_store_cycle", cyc, 11);
    check("prog_store_data", {ram_addr, ram_wdata}, {12'h020, 8'h08});

    // SKZ at pc 5 with acc==0 and acc!=0
    for (int z = 0; z < 2; z++) begin
      reset = 1'b0;
      clear_mem();
      ram[12'h030] = (z == 0) ? 8'h00 : 8'h01;
      rom[0] = 16'h1030;
      rom[5] = 16'hB000;
      rom[6] = 16'hC000;
      rom[7] = 16'hC000;
      release_reset();
      wait_fetch(12'h005, "skz_tmo");
      step(3);
      check($sformatf("skz_next_%0d", z), {rom_rd, rom_addr}, (z == 0) ? {1'b1, 12'h007} : {1'b1, 12'h006});
    end

    // pc wrap: NOP and SKZ at 0xFFF
    for (int k = 0; k < 2; k++) begin
      reset = 1'b0;
      clear_mem();
      rom[0] = 16'hAFFF;
      rom[12'hFFF] = (k == 0) ? 16'h0000 : 16'hB000;
      release_reset();
      wait_fetch(12'hFFF, "wrap_tmo");
      step(3);
      check($sformatf("wrap_next_%0d", k), {rom_rd, rom_addr}, (k == 0) ? {1'b1, 12'h000} : {1'b1, 12'h001});
    end

    // HLT: terminal, strobes quiet
    reset = 1'b0;
    clear_mem();
    rom[0] = 16'hC000;
    rom[1] = 16'h1000;
    release_reset();
    step(3);
    check("hlt_state", {halted, illegal}, 2'b10);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rom_rd || ram_rd || ram_wr || !halted) strobes++;
    end
    check("hlt_quiet", strobes, 0);

    // op 0xD
    reset = 1'b0;
    clear_mem();
    rom[0] = 16'hD000;
    rom[1] = 16'hC000;
    release_reset();
    step(3);
`ifdef ALU_CTRL_TRAP_EN
    check("illegal_trap", {halted, illegal, rom_rd}, 3'b110);
`else
    check("illegal_as_nop", {halted, illegal, rom_rd, rom_addr}, {3'b001, 12'h001});
    step(3);
    check("illegal_then_hlt", {halted, illegal}, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
